// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave front end. Accepts pipelined address phases, checks size/address
// alignment, drives a simple back-end request (sel/addr/write/wdata/strb/prot) and
// maps back-end ready/error and a data-phase timeout onto the AHB two-cycle ERROR response.
module ahb_slave_ctrl #(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int AHB_DATA_WIDTH = 32,
   parameter int TIMEOUT        = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   // AHB slave side
   input  logic                        hsel,
   input  logic [AHB_ADDR_WIDTH-1:0]   haddr,
   input  logic [1:0]                  htrans,
   input  logic                        hwrite,
   input  logic [2:0]                  hsize,
   input  logic [3:0]                  hprot,
   input  logic [AHB_DATA_WIDTH-1:0]   hwdata,
   input  logic                        hready,
   output logic                        hreadyout,
   output logic                        hresp,
   output logic [AHB_DATA_WIDTH-1:0]   hrdata,
   // back-end request
   output logic                        sel,
   output logic [AHB_ADDR_WIDTH-1:0]   addr,
   output logic                        write,
   output logic [AHB_DATA_WIDTH-1:0]   wdata,
   output logic [AHB_DATA_WIDTH/8-1:0] strb,
   output logic [3:0]                  prot,
   // back-end response
   input  logic                        ready,
   input  logic [AHB_DATA_WIDTH-1:0]   rdata,
   input  logic                        slave_error,
   input  logic                        other_error
);

   localparam int STRB_W = AHB_DATA_WIDTH / 8;
   localparam int LANE_W = $clog2(STRB_W);
   localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_ERR1   = 2'd2,
      S_ERR2   = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                      write_q, write_d;
   logic [3:0]                prot_q, prot_d;
   logic [2:0]                size_q, size_d;
   logic [WAIT_W-1:0]         wait_q, wait_d;

   logic              phase_valid;
   logic              misaligned;
   logic              backend_err;
   logic              take_phase;
   logic [2:0]        align_mask;
   logic [WAIT_W-1:0] wait_inc;
   logic              timeout_hit;
   logic [STRB_W-1:0] size_bytes;

   // NONSEQ and SEQ are the only transfer types that reach the back end.
   assign phase_valid = hsel && hready && (htrans inside {2'b10, 2'b11});
   assign backend_err = slave_error || other_error;
   assign wait_inc    = wait_q + 1'b1;
   assign timeout_hit = (TIMEOUT != 0) && (wait_inc == WAIT_W'(TIMEOUT));

   // Alignment check: size must fit the bus and the address must be a multiple of the size.
   always_comb begin
      case (hsize)
         3'd0:    align_mask = 3'b000;
         3'd1:    align_mask = 3'b001;
         3'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
      misaligned = (hsize > 3'(LANE_W)) || ((haddr[2:0] & align_mask) != 3'b000);
   end

   // Next state and captured address-phase fields.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
      state_d    = state_q;
      addr_d     = addr_q;
      write_d    = write_q;
      prot_d     = prot_q;
      size_d     = size_q;
      wait_d     = wait_q;
      take_phase = 1'b0;
      case (state_q)
         S_IDLE:   take_phase = 1'b1;
         S_ACCESS: begin
            if (ready && backend_err) begin
               state_d = S_ERR1;
            end else if (ready) begin
               take_phase = 1'b1;
            end else begin
               wait_d = wait_inc;
               if (timeout_hit) state_d = S_ERR1;
            end
         end
         S_ERR1:   state_d = S_ERR2;
         S_ERR2:   take_phase = 1'b1;
         default:  state_d = S_IDLE;
      endcase
      // Shared address-phase acceptance: IDLE, a completing ACCESS and ERR2 all sample the bus.
      if (take_phase) begin
         if (phase_valid) begin
            addr_d  = haddr;
            write_d = hwrite;
            prot_d  = hprot;
            size_d  = hsize;
            wait_d  = '0;
            state_d = misaligned ? S_ERR1 : S_ACCESS;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   // State and request registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         prot_q  <= '0;
         size_q  <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         prot_q  <= prot_d;
         size_q  <= size_d;
         wait_q  <= wait_d;
      end
   end

   // Byte-lane mask for the captured transfer size.
   always_comb begin
      case (size_q)
         3'd0:    size_bytes = STRB_W'(8'h01);
         3'd1:    size_bytes = STRB_W'(8'h03);
         3'd2:    size_bytes = STRB_W'(8'h0F);
         default: size_bytes = STRB_W'(8'hFF);
      endcase
   end

   // AHB response and back-end data path, decoded from the current state.
   always_comb begin
      hreadyout = 1'b1;
      hresp     = 1'b0;
      hrdata    = '0;
      sel       = 1'b0;
      wdata     = '0;
      strb      = '0;
      case (state_q)
         S_ACCESS: begin
            sel       = 1'b1;
            hreadyout = ready && !backend_err;
            strb      = size_bytes << addr_q[LANE_W-1:0];
            if (write_q)            wdata  = hwdata;
            if (ready && !write_q)  hrdata = rdata;
         end
         S_ERR1: begin
            hreadyout = 1'b0;
            hresp     = 1'b1;
         end
         S_ERR2:  hresp = 1'b1;
         default: ;
      endcase
   end

   assign addr  = addr_q;
   assign write = write_q;
   assign prot  = prot_q;

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Self-checking bench for ahb_slave_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_ahb_slave_ctrl;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int NB    = DW / 8;
   localparam int LANES = 2;
   localparam int TO    = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          hsel, hwrite, hready, hreadyout, hresp;
   logic [AW-1:0] haddr, addr;
   logic [1:0]    htrans;
   logic [2:0]    hsize;
   logic [3:0]    hprot, prot;
   logic [DW-1:0] hwdata, hrdata, wdata, rdata;
   logic          sel, write, ready, slave_error, other_error;
   logic [NB-1:0] strb;

   ahb_slave_ctrl #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
      .hprot(hprot), .hwdata(hwdata), .hready(hready),
      .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
      .sel(sel), .addr(addr), .write(write), .wdata(wdata), .strb(strb), .prot(prot),
      .ready(ready), .rdata(rdata), .slave_error(slave_error), .other_error(other_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: an outstanding transfer plus a count of ERROR cycles still to show.
   bit            m_busy     = 1'b0;
   int            m_err_left = 0;
   logic [AW-1:0] m_addr     = '0;
   bit            m_write    = 1'b0;
   int            m_size     = 0;
   logic [3:0]    m_prot     = '0;
   int            m_waits    = 0;
   bit            rand_hready = 1'b0;

   function automatic bit is_misaligned(input int size, input logic [AW-1:0] a);
      return (size > LANES) || ((int'(a[7:0]) % (1 << size)) != 0);
   endfunction

   function automatic logic [NB-1:0] model_strb(input int size, input logic [AW-1:0] a);
      int nbytes = 1 << size;
      int lane   = int'(a[7:0]) % NB;
      int v      = ((1 << nbytes) - 1) << lane;
      return NB'(v);
   endfunction

   // Called just after a falling edge with inputs already driven: checks outputs,
   // advances the model by one rising edge, and returns at the next falling edge.
   task automatic tick();
      bit            bad = slave_error || other_error;
      logic          e_hro, e_resp, e_sel;
      logic [DW-1:0] e_rdata, e_wdata;
      e_hro = 1'b1; e_resp = 1'b0; e_sel = 1'b0; e_rdata = '0; e_wdata = '0;
      if (m_err_left == 2) begin
         e_hro = 1'b0; e_resp = 1'b1;
      end else if (m_err_left == 1) begin
         e_resp = 1'b1;
      end else if (m_busy) begin
         e_sel = 1'b1;
         e_hro = ready && !bad;
         if (m_write) e_wdata = hwdata;
         else if (ready) e_rdata = rdata;
      end
      hready = rand_hready ? (e_hro && ($urandom_range(0, 7) != 0)) : e_hro;
      #1;
      check("hreadyout", hreadyout, e_hro);
      check("hresp", hresp, e_resp);
      check("sel", sel, e_sel);
      check("hrdata", hrdata, e_rdata);
      check("wdata", wdata, e_wdata);
      if (e_sel) begin
         check("addr", addr, m_addr);
         check("write", write, m_write);
         check("strb", strb, model_strb(m_size, m_addr));
         check("prot", prot, m_prot);
      end
      if (rst) begin
         m_busy = 1'b0; m_err_left = 0; m_waits = 0;
      end else if (m_err_left == 2) begin
         m_err_left = 1;
      end else if (m_busy && !ready) begin
         m_waits++;
         if (TO > 0 && m_waits == TO) begin
            m_busy = 1'b0; m_err_left = 2;
         end
      end else if (m_busy && bad) begin
         m_busy = 1'b0; m_err_left = 2;
      end else begin
         m_err_left = 0;
         m_busy     = 1'b0;
         if (hsel && hready && htrans[1]) begin
            m_addr = haddr; m_write = hwrite; m_size = int'(hsize); m_prot = hprot;
            if (is_misaligned(int'(hsize), haddr)) m_err_left = 2;
            else begin
               m_busy = 1'b1; m_waits = 0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic addr_phase(input logic [AW-1:0] a, input logic w, input logic [2:0] sz);
      hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; hprot = 4'(($urandom));
   endtask

   task automatic bus_idle();
      hsel = 1'b0; htrans = 2'b00;
   endtask

   initial begin
      rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = '0; hwrite = 1'b0; hsize = '0;
      hprot = '0; hwdata = '0; hready = 1'b1; ready = 1'b0; rdata = '0;
      slave_error = 1'b0; other_error = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_hreadyout", hreadyout, 1'b1);
      check("rst_hresp", hresp, 1'b0);
      check("rst_hrdata", hrdata, '0);
      check("rst_sel", sel, 1'b0);
      check("rst_addr", addr, '0);
      check("rst_write", write, 1'b0);
      check("rst_wdata", wdata, '0);
      check("rst_strb", strb, '0);
      check("rst_prot", prot, '0);
      tick();
      rst = 1'b0;

      // Single-cycle write.
      addr_phase(32'h104, 1'b1, 3'd2); ready = 1'b1;
      tick();
      bus_idle(); hwdata = 32'hDEADBEEF;
      #1;
      check("wr_sel", sel, 1'b1);
      check("wr_addr", addr, 32'h104);
      check("wr_strb", strb, 4'b1111);
      check("wr_wdata", wdata, 32'hDEADBEEF);
      check("wr_hreadyout", hreadyout, 1'b1);
      check("wr_hresp", hresp, 1'b0);
      tick();

      // Read with three wait cycles.
      addr_phase(32'h20, 1'b0, 3'd2);
      tick();
      bus_idle(); ready = 1'b0; rdata = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         #1 check("rd_wait_hreadyout", hreadyout, 1'b0);
         tick();
      end
      ready = 1'b1;
      #1;
      check("rd_done_hreadyout", hreadyout, 1'b1);
      check("rd_done_hrdata", hrdata, 32'h12345678);
      tick();

      // Misaligned halfword.
      addr_phase(32'h3, 1'b0, 3'd1);
      tick();
      bus_idle();
      #1;
      check("mis_err1_sel", sel, 1'b0);
      check("mis_err1_hreadyout", hreadyout, 1'b0);
      check("mis_err1_hresp", hresp, 1'b1);
      tick();
      check("mis_err2_hreadyout", hreadyout, 1'b1);
      check("mis_err2_hresp", hresp, 1'b1);
      check("mis_err2_sel", sel, 1'b0);
      tick();

      // Back-end error on a write, then a new transfer accepted in ERR2.
      addr_phase(32'h8, 1'b1, 3'd2);
      tick();
      bus_idle(); slave_error = 1'b1; ready = 1'b1;
      #1 check("be_access_hreadyout", hreadyout, 1'b0);
      tick();
      slave_error = 1'b0;
      #1;
      check("be_err1_hresp", hresp, 1'b1);
      check("be_err1_sel", sel, 1'b0);
      tick();
      addr_phase(32'h10, 1'b0, 3'd2);
      #1 check("be_err2_hreadyout", hreadyout, 1'b1);
      tick();
      bus_idle();
      #1;
      check("be_next_sel", sel, 1'b1);
      check("be_next_addr", addr, 32'h10);
      tick();

      // Timeout with ready held low.
      addr_phase(32'h40, 1'b0, 3'd2);
      tick();
      bus_idle(); ready = 1'b0;
      for (int i = 0; i < TO; i++) begin
         #1 check("to_wait_sel", sel, 1'b1);
         tick();
      end
      #1;
      check("to_err1_sel", sel, 1'b0);
      check("to_err1_hresp", hresp, 1'b1);
      check("to_err1_hreadyout", hreadyout, 1'b0);
      tick();
      check("to_err2_hreadyout", hreadyout, 1'b1);
      check("to_err2_hresp", hresp, 1'b1);
      tick();

      // Back-to-back pipelined transfers.
      ready = 1'b1;
      addr_phase(32'h0, 1'b1, 3'd2);
      tick();
      addr_phase(32'h4, 1'b1, 3'd2);
      #1;
      check("b2b_first_sel", sel, 1'b1);
      check("b2b_first_addr", addr, 32'h0);
      tick();
      bus_idle();
      #1;
      check("b2b_second_sel", sel, 1'b1);
      check("b2b_second_addr", addr, 32'h4);
      tick();
      #1 check("b2b_after_sel", sel, 1'b0);

      // Reset in the middle of a data phase, then a fresh transfer.
      addr_phase(32'h80, 1'b0, 3'd2); ready = 1'b0;
      tick();
      bus_idle();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rst_mid_hresp", hresp, 1'b0);
      check("rst_mid_sel", sel, 1'b0);
      addr_phase(32'hC, 1'b1, 3'd2); ready = 1'b1;
      tick();
      #1 check("rst_mid_next_sel", sel, 1'b1);
      bus_idle();
      tick();

      // Random traffic against the model.
      rand_hready = 1'b1;
      begin
         bit slow = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            int sz, a;
            if (i % 64 == 0) slow = ($urandom_range(0, 2) == 0);
            rst    = ($urandom_range(0, 149) == 0);
            hsel   = ($urandom_range(0, 7) != 0);
            htrans = 2'($urandom);
            hwrite = 1'($urandom);
            sz     = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(0, 7);
            a      = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a - (a % (1 << sz));
            haddr  = AW'(a);
            hsize  = 3'(sz);
            hprot  = 4'($urandom);
            hwdata = $urandom;
            rdata  = $urandom;
            ready  = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
            slave_error = ($urandom_range(0, 11) == 0);
            other_error = ($urandom_range(0, 11) == 0);
            tick();
         end
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
